// File: rtl/mem_pkg.sv
// Shared types and default sizing for the run-time loadable memory.
// Imported by mem_writer.
package mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_ADDR_LENTH = 16;

endpackage

// File: rtl/mem_writer.sv
// Write-side loader for the lookup memory: handshake writes, auto fill,
// sequenced clear, async read port.
module mem_writer
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ADDR_LENTH = DEF_ADDR_LENTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  auto_inc,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  full,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   wr_count
);

  localparam logic [ADDR_WIDTH:0] LEN =
    (ADDR_WIDTH+1)'(ADDR_LENTH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(ADDR_LENTH - 1);

  state_t r_state;
  state_t w_next;

  logic [DATA_WIDTH-1:0] r_mem [ADDR_LENTH];
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] r_clr_idx;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_full;
  logic                  r_err;

  logic [ADDR_WIDTH-1:0] w_tgt;
  logic                  w_ready;
  logic                  w_busy;
  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_clr_done;

  assign w_tgt      = auto_inc ? r_ptr : wr_addr;
  assign w_in_range = ({1'b0, w_tgt} < LEN);
  assign w_accept   = wr_valid && w_ready;
  assign w_clr_done = (r_state == CLEAR) && (r_clr_idx == LAST);

  assign wr_ready = w_ready;
  assign busy     = w_busy;
  assign full     = r_full;
  assign err      = r_err;
  assign wr_count = r_cnt;

  assign rd_data = ({1'b0, rd_addr} < LEN) ?
                   r_mem[rd_addr] : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and handshake/busy outputs; clr wins over a write.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready = !clr;
        if (clr) w_next = CLEAR;
      end
      CLEAR: begin
        w_busy = 1'b1;
        if (r_clr_idx == LAST) w_next = IDLE;
      end
    endcase
  end

  // Storage: one entry zeroed per clear cycle, else accepted writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ADDR_LENTH; i++) r_mem[i] <= '0;
    end else if (r_state == CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_accept && w_in_range) begin
      r_mem[w_tgt] <= wr_data;
    end
  end

  // Clear sweep index, rearmed to 0 on the final clear cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_idx <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_idx <= w_clr_done ? '0 : r_clr_idx + 1'b1;
    end
  end

  // Fill pointer, wrap flag, write counter and range-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_full <= 1'b0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_accept && !auto_inc && !w_in_range;
      if (w_clr_done) begin
        r_ptr  <= '0;
        r_full <= 1'b0;
        r_cnt  <= '0;
      end else if (w_accept) begin
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        if (auto_inc) begin
          if (r_ptr == LAST) begin
            r_ptr  <= '0;
            r_full <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/mem_writer.md
Name: mem_writer

Overview:
Write-side companion to the lab4 lookup memory. It accepts (address, data) words over a valid/ready handshake and stores them in an internal register array. It also offers an auto-increment fill mode and a sequenced clear command. Contents are exposed on an asynchronous read port with the same semantics as the existing memory block, so this unit loads tables at run time instead of via hex file.

Parameters:
DATA_WIDTH, 8, width of each stored word and of wr_data/rd_data
ADDR_WIDTH, 4, width of wr_addr/rd_addr
ADDR_LENTH, 16, number of entries (≤ 2^ADDR_WIDTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  request to zero every entry (level sampled in IDLE)
auto_inc  input  1  1: use internal write pointer, ignore wr_addr; 0: use wr_addr
wr_valid  input  1  write request valid
wr_ready  output  1  unit can accept a write this cycle
wr_addr  input  ADDR_WIDTH  explicit write address
wr_data  input  DATA_WIDTH  write data
rd_addr  input  ADDR_WIDTH  read address
rd_data  output  DATA_WIDTH  combinational read data
busy  output  1  clear sequence in progress
full  output  1  sticky: auto pointer has wrapped at least once
err  output  1  one-cycle pulse: explicit write to out-of-range address dropped
wr_count  output  ADDR_WIDTH+1  accepted writes since reset/clear, saturating

Behaviour:
- Reset (async, rst_n=0): all entries 0, state IDLE, ptr 0, full 0, err 0, wr_count 0, busy 0. wr_ready = !clr while in reset-released IDLE.
- States: IDLE, CLEAR.
- wr_ready = (state==IDLE) && !clr (combinational). Handshake fires when wr_valid && wr_ready at a rising edge.
- Write latency: entry updated on the accepting edge. rd_data shows the new value immediately after that edge.
- Target address = auto_inc ? ptr : wr_addr.
- Auto mode: on accept, ptr increments. At ADDR_LENTH-1, ptr wraps to 0 and full sets. full holds until clear or reset.
- Explicit mode, wr_addr ≥ ADDR_LENTH: array unchanged, handshake still completes, err=1 for the next cycle only, wr_count still increments. ptr unaffected in explicit mode.
- wr_count increments on every accept and saturates at 2^(ADDR_WIDTH+1)-1.
- IDLE, clr=1 at edge → CLEAR. clr has priority over a simultaneous wr_valid; that write is not accepted because ready is low.
- CLEAR: busy=1, wr_ready=0. Zeroes one entry per cycle starting at index 0. Returns to IDLE on the edge that zeroes index ADDR_LENTH-1, so CLEAR lasts exactly ADDR_LENTH cycles. On exit: ptr=0, full=0, wr_count=0. clr held or re-asserted during CLEAR is ignored; a clr still high in IDLE starts another clear.
- Reads during CLEAR return the current contents (partially cleared).
- rd_addr ≥ ADDR_LENTH → rd_data = 0.
- Reset mid-CLEAR or mid-transfer: immediate return to the reset state above.

Decomposition:
- Shared package mem_pkg: state enum (IDLE, CLEAR), default DATA_WIDTH/ADDR_WIDTH/ADDR_LENTH constants.
- Single module. The clear index and ptr are separate counters in the same module; no sub-module is warranted.

Test Plan:
- Reset then explicit writes addr 3←0xA5, addr 15←0x3C → rd_addr 3 gives 0xA5, rd_addr 15 gives 0x3C, wr_count=2, err never asserted.
- auto_inc=1, 16 consecutive writes of 0x10..0x1F → entry i = 0x10+i, full rises on the 16th accept, ptr back to 0. A 17th write of 0xEE overwrites entry 0.
- ADDR_LENTH=12: explicit write to addr 13 → no array change, err high exactly one cycle, wr_count increments. rd_addr 13 returns 0.
- clr and wr_valid asserted the same IDLE cycle → wr_ready=0, write not taken. busy high 16 cycles, then all entries 0, full=0, wr_count=0, wr_ready=1.
- rst_n pulsed low at cycle 5 of CLEAR (entries preloaded 0xFF) → all entries immediately 0, busy=0, state IDLE.
- wr_valid held with constant data for 40 cycles (ADDR_WIDTH=4) → wr_count saturates at 31.
